// File: rtl/seq_mult_shift_add.sv
// Radix-2 shift-and-add sequential multiplier with start/done handshake.
// Signed operands are reduced to magnitudes up front; the sign is reapplied
// once when the result is written, so the RUN datapath stays purely unsigned.
module seq_mult_shift_add #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               acc_mode,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] acc
);
  localparam int PW = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic             accm_q, accm_d;
  logic [PW-1:0]    pp_q, pp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;

  logic [WIDTH-1:0] m_abs, q_abs;
  logic [PW-1:0]    addend, pp_step, res;

  // Operand magnitudes and the step datapath; the last step's add is folded
  // into the result so acc is written on the same edge that leaves RUN.
  always_comb begin
    m_abs   = (signed_mode && M[WIDTH-1]) ? -M : M;
    q_abs   = (signed_mode && Q[WIDTH-1]) ? -Q : Q;
    addend  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    pp_step = pp_q + addend;
    res     = neg_q ? -pp_step : pp_step;
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    accm_d   = accm_q;
    pp_d     = pp_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          mcand_d  = m_abs;
          mplier_d = q_abs;
          neg_d    = signed_mode & (M[WIDTH-1] ^ Q[WIDTH-1]);
          accm_d   = acc_mode;
          pp_d     = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        pp_d     = pp_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = DONE;
          acc_d   = accm_q ? acc_q + res : res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      accm_q   <= 1'b0;
      pp_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      accm_q   <= accm_d;
      pp_q     <= pp_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign acc   = acc_q;
endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: the driver pushes expected results
// computed with plain integer multiplication, a monitor pops them on done.
module tb_seq_mult_shift_add;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset, start, signed_mode, acc_mode;
  logic [W-1:0]  M, Q;
  logic          ready, busy, done;
  logic [2*W-1:0] acc;

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .acc_mode(acc_mode), .M(M), .Q(Q), .ready(ready), .busy(busy),
    .done(done), .acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2*W-1:0] val; int cyc; } exp_t;
  exp_t           sb[$];
  int             checks = 0, failures = 0;
  int             cyc = 0;
  logic [2*W-1:0] model_acc = '0;
  logic [2*W-1:0] prev_acc = '0;
  logic           rst_seen = 1'b1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) rst_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head, and make
  // sure acc never moves outside a done/reset.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: acc=%0h with empty scoreboard", acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc", acc, e.val);
        chk("latency", cyc, e.cyc);
      end
    end else if (!reset && !rst_seen && acc !== prev_acc) begin
      checks++; failures++;
      $display("FAIL acc_stable: acc changed %0h -> %0h without done", prev_acc, acc);
    end
    prev_acc = acc;
    if (!reset) rst_seen = 1'b0;
  end

  // Reference product: plain integer multiplication of the interpreted operands.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm);
    longint a, b, p;
    a = sm ? longint'($signed(m)) : longint'(m);
    b = sm ? longint'($signed(q)) : longint'(q);
    p = a * b;
    return p[2*W-1:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      $display("FAIL ready_timeout: ready=%0b expected 1", ready);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "ready timeout");
    end
  endtask

  // Issue one operation at the current negedge (waiting for ready first).
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm, input logic am);
    exp_t e;
    wait_ready();
    M = m; Q = q; signed_mode = sm; acc_mode = am; start = 1'b1;
    model_acc = am ? model_acc + ref_prod(m, q, sm) : ref_prod(m, q, sm);
    @(posedge clk); #1;
    e.val = model_acc;
    e.cyc = cyc + W;
    sb.push_back(e);
    start = 1'b0;
    M = W'($urandom); Q = W'($urandom);
    signed_mode = 1'($urandom); acc_mode = 1'($urandom);
    chk("busy_after_start", {busy, ready}, 2'b10);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout: done=%0b expected 1", done);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0; M = '0; Q = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc, 0); chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(negedge clk); reset = 1'b0; @(negedge clk);

    // Reset mid-RUN: discard the operation and its expected result.
    do_op(16'd5, 16'd7, 1'b0, 1'b0);
    idle(3);
    reset = 1'b1; @(posedge clk); #1;
    sb.delete(); model_acc = '0;
    chk("midrun_acc", acc, 0); chk("midrun_ready", ready, 1);
    chk("midrun_busy", busy, 0); chk("midrun_done", done, 0);
    @(negedge clk); reset = 1'b0;
    idle(25);

    // Directed corner cases.
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0); wait_done();
    do_op(16'hFFFD, 16'd7,    1'b1, 1'b0); wait_done();
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0); wait_done();
    chk("signed_full_range", acc, 32'h40000000);
    idle(2);
    // Back-to-back accumulate issued in the DONE cycle.
    do_op(16'd3, 16'd4, 1'b0, 1'b0); wait_done();
    chk("acc_first", acc, 32'd12);
    do_op(16'd5, 16'd6, 1'b0, 1'b1); wait_done();
    chk("acc_second", acc, 32'd42);
    idle(2);
    // Start during RUN must be ignored.
    do_op(16'd2, 16'd3, 1'b0, 1'b0);
    idle(3);
    M = 16'd9; Q = 16'd9; start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    chk("busy_protect", acc, 32'd6);
    idle(3);
    // Wrap modulo 2^(2W), then a zero product leaves acc unchanged.
    do_op(16'hFFFF, 16'd1, 1'b1, 1'b0); wait_done();
    do_op(16'd1, 16'd1, 1'b0, 1'b1); wait_done();
    chk("wrap", acc, 32'h0);
    do_op(16'd7, 16'd9, 1'b0, 1'b0); wait_done();
    do_op(16'd0, 16'h1234, 1'b0, 1'b1); wait_done();
    chk("zero_acc", acc, 32'd63);

    // Randomized operations with random gaps and back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] m, q;
      case ($urandom_range(0, 5))
        0: m = 16'h8000; 1: m = 16'hFFFF; 2: m = 16'h0000;
        default: m = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: q = 16'h8000; 1: q = 16'h7FFF; 2: q = 16'h0001;
        default: q = W'($urandom);
      endcase
      do_op(m, q, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        wait_done();
        idle($urandom_range(0, 3));
      end
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    end
    chk("scoreboard_empty", sb.size(), 0);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
